boot_loader: RTL and testbench

- Sits upstream of the single-cycle RISC-V core and its instruction memory.
- While the core is held in reset, it receives a program image as a byte stream over a valid/ready handshake.
- It assembles the bytes into little-endian 32-bit words, writes them into instruction memory starting at word 0, verifies an XOR checksum, then releases the core's reset.

---
 rtl/boot_pkg.sv | 30 +++
 rtl/boot_loader_word_assembler.sv | 52 +++++
 rtl/boot_loader.sv | 142 ++++++++++++++
 tb/tb_boot_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : boot_pkg
// Description : Shared constants and state encoding for the boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
package boot_pkg;

    localparam int         LEN_WIDTH         = 16;
    localparam int         STATE_WIDTH       = 3;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef logic [STATE_WIDTH-1:0] state_t;

    localparam state_t ST_WAIT_SYNC = 3'd0;
    localparam state_t ST_LEN_LO    = 3'd1;
    localparam state_t ST_LEN_HI    = 3'd2;
    localparam state_t ST_DATA      = 3'd3;
    localparam state_t ST_CHECK     = 3'd4;
    localparam state_t ST_RUN       = 3'd5;
    localparam state_t ST_ERROR     = 3'd6;

    // States in which the loader offers rx_ready to the byte source.
    function automatic logic accepts_bytes(input state_t st);
        return (st == ST_WAIT_SYNC) || (st == ST_LEN_LO) || (st == ST_LEN_HI) ||
               (st == ST_DATA)      || (st == ST_CHECK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/boot_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Little-endian byte-to-word packer with running XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic        o_word_done,
    output logic [31:0] o_word,
    output logic [7:0]  o_chksum
);

    logic [23:0] r_shift;
    logic [1:0]  r_idx;
    logic [7:0]  r_chksum;

    // The fourth byte is used straight from the input so the word is
    // complete on the same edge that accepts it.
    assign o_word_done = i_byte_en && (r_idx == 2'd3);
    assign o_word      = {i_byte, r_shift};
    assign o_chksum    = r_chksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_idx    <= '0;
            r_chksum <= '0;
        end else if (i_clr) begin
            r_shift  <= '0;
            r_idx    <= '0;
            r_chksum <= '0;
        end else if (i_byte_en) begin
            case (r_idx)
                2'd0:    r_shift[7:0]   <= i_byte;
                2'd1:    r_shift[15:8]  <= i_byte;
                2'd2:    r_shift[23:16] <= i_byte;
                default: r_shift        <= r_shift;
            endcase
            r_idx    <= r_idx + 2'd1;
            r_chksum <= r_chksum ^ i_byte;
        end
    end

endmodule
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader
// Description : Receives a framed program image, writes it to instruction
//               memory, verifies the XOR checksum and releases the core.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_loader
    import boot_pkg::*;
#(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error
);

    // Largest legal word count: a full-depth image.
    localparam logic [LEN_WIDTH:0] c_depth = {{LEN_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;

    state_t                r_state;
    state_t                w_next;
    logic                  r_rx_ready;
    logic                  r_cpu_rst;
    logic                  r_done;
    logic                  r_error;
    logic [7:0]            r_len_lo;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_word_cnt;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [31:0]           r_imem_wdata;

    logic                  w_accept;
    logic                  w_sync_hit;
    logic                  w_byte_en;
    logic                  w_word_done;
    logic [31:0]           w_word;
    logic [7:0]            w_chksum;
    logic [LEN_WIDTH-1:0]  w_len_full;

    assign w_accept   = rx_valid && r_rx_ready;
    assign w_sync_hit = w_accept && (r_state == ST_WAIT_SYNC) && (rx_data == SYNC_BYTE);
    assign w_byte_en  = w_accept && (r_state == ST_DATA);
    assign w_len_full = {rx_data, r_len_lo};

    word_assembler u_word_assembler (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_sync_hit),
        .i_byte_en   (w_byte_en),
        .i_byte      (rx_data),
        .o_word_done (w_word_done),
        .o_word      (w_word),
        .o_chksum    (w_chksum)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_WAIT_SYNC: begin
                if (w_sync_hit) w_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (w_accept) w_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (w_accept) begin
                    if ({1'b0, w_len_full} > c_depth) w_next = ST_ERROR;
                    else if (w_len_full == '0)        w_next = ST_CHECK;
                    else                              w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_word_done && (r_word_cnt == r_len - LEN_WIDTH'(1))) w_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_accept) w_next = (rx_data == w_chksum) ? ST_RUN : ST_ERROR;
            end
            ST_RUN:   w_next = ST_RUN;
            ST_ERROR: w_next = ST_ERROR;
            default:  w_next = ST_ERROR;
        endcase
    end

    // Status outputs are registered from the next state so they change on
    // the same edge that enters RUN or ERROR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_WAIT_SYNC;
            r_rx_ready <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_len_lo   <= '0;
            r_len      <= '0;
        end else begin
            r_state    <= w_next;
            r_rx_ready <= accepts_bytes(w_next);
            r_cpu_rst  <= (w_next != ST_RUN);
            r_done     <= (w_next == ST_RUN);
            r_error    <= (w_next == ST_ERROR);
            if (w_accept && (r_state == ST_LEN_LO)) r_len_lo <= rx_data;
            if (w_accept && (r_state == ST_LEN_HI)) r_len    <= w_len_full;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_word_cnt   <= '0;
        end else begin
            r_imem_we <= w_word_done;
            if (w_word_done) begin
                r_imem_addr  <= r_word_cnt[ADDR_WIDTH-1:0];
                r_imem_wdata <= w_word;
                r_word_cnt   <= r_word_cnt + LEN_WIDTH'(1);
            end
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign done       = r_done;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_boot_loader
// Description : Frame vectors plus write scoreboard for the boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_loader;
    import boot_pkg::*;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          error;

    always #5 clk = ~clk;

    boot_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    typedef struct {
        string       name;
        int          off;
        int          nb;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] pool[$];
    vec_t       vecs[5];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_writes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && imem_we) begin
                n_writes++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                             imem_addr, imem_wdata);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                    chk("wr_data", imem_wdata, e.data);
                end
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "/cpu_rst"},   32'(cpu_rst),    32'd1);
        chk({tag, "/rx_ready"},  32'(rx_ready),   32'd0);
        chk({tag, "/imem_we"},   32'(imem_we),    32'd0);
        chk({tag, "/imem_addr"}, 32'(imem_addr),  32'd0);
        chk({tag, "/imem_wdata"}, imem_wdata,     32'd0);
        chk({tag, "/done"},      32'(done),       32'd0);
        chk({tag, "/error"},     32'(error),      32'd0);
        chk({tag, "/state"},     32'(dut.r_state), 32'(ST_WAIT_SYNC));
    endtask

    // Asserts rst mid-cycle (asynchronously), optionally checks, releases at a negedge.
    task automatic do_reset(input bit check_it, input string tag);
        #2 rst = 1'b1;
        rx_valid = 1'b0;
        #1;
        if (check_it) check_reset_values(tag);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_writes = 0;
    endtask

    // Entered and left at a negedge; returns once the byte has been accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, output logic pre_cpu_rst);
        bit got;
        int n;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        pre_cpu_rst = cpu_rst;
        forever begin
            got = rx_ready;
            pre_cpu_rst = cpu_rst;
            @(posedge clk);
            if (got) break;
            n++;
            if (n > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: got no rx_ready for byte %h, expected acceptance", b);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic play_vec(input int i, input bit gappy);
        logic pre;
        vec_t v;
        v = vecs[i];
        pre = 1'b1;
        if (v.nw >= 1) sb.push_back('{addr: AW'(0), data: v.w0});
        if (v.nw >= 2) sb.push_back('{addr: AW'(1), data: v.w1});
        for (int k = 0; k < v.nb; k++)
            send_byte(pool[v.off + k], gappy ? int'($urandom_range(0, 3)) : 0, pre);
        if (v.exp_done) chk({v.name, "/cpu_rst_before"}, 32'(pre), 32'd1);
        chk({v.name, "/cpu_rst"}, 32'(cpu_rst), 32'(!v.exp_done));
        chk({v.name, "/done"},    32'(done),    32'(v.exp_done));
        repeat (3) @(negedge clk);
        chk({v.name, "/error"},    32'(error),    32'(v.exp_err));
        chk({v.name, "/rx_ready"}, 32'(rx_ready), 32'd0);
        chk({v.name, "/writes"},   32'(n_writes), 32'(v.nw));
        chk({v.name, "/sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic        pre;
        logic [31:0] w;
        logic [7:0]  cs;

        // Checksum of 13 05 10 00 93 05 20 00 is B0; A9 is deliberately wrong.
        pool = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0,
                8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hA9,
                8'h00, 8'hFF, 8'h5A,
                8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0,
                8'hA5, 8'h11, 8'h00,
                8'hA5, 8'h00, 8'h00, 8'h00};
        vecs[0] = '{"nominal",  0,  12, 2, 32'h00100513, 32'h00200593, 1'b1, 1'b0};
        vecs[1] = '{"bad_chk",  12, 12, 2, 32'h00100513, 32'h00200593, 1'b0, 1'b1};
        vecs[2] = '{"garbage",  24, 15, 2, 32'h00100513, 32'h00200593, 1'b1, 1'b0};
        vecs[3] = '{"oversize", 39, 3,  0, 32'h0,        32'h0,        1'b0, 1'b1};
        vecs[4] = '{"zero_len", 42, 4,  0, 32'h0,        32'h0,        1'b1, 1'b0};

        fork
            monitor();
        join_none

        @(negedge clk);
        do_reset(1'b1, "reset");

        for (int i = 0; i < 5; i++) begin
            do_reset(1'b0, "");
            play_vec(i, 1'b0);
        end

        // Nominal frame with random idle gaps on rx_valid.
        do_reset(1'b0, "");
        vecs[0].name = "gappy";
        play_vec(0, 1'b1);
        vecs[0].name = "nominal";

        // Reset after 6 data bytes, then a fresh frame without another reset.
        do_reset(1'b0, "");
        sb.push_back('{addr: AW'(0), data: 32'h00100513});
        for (int k = 0; k < 9; k++) send_byte(pool[k], 0, pre);
        chk("midrst/word0_written", 32'(sb.size()), 32'd0);
        do_reset(1'b1, "midrst");
        play_vec(0, 1'b0);

        // Full-depth image: LEN = 16 with AW = 4, last write at address 15.
        do_reset(1'b0, "");
        send_byte(8'hA5, 0, pre);
        send_byte(8'h10, 0, pre);
        send_byte(8'h00, 0, pre);
        cs = 8'h00;
        for (int wi = 0; wi < 16; wi++) begin
            w = $urandom;
            sb.push_back('{addr: AW'(wi), data: w});
            for (int b = 0; b < 4; b++) begin
                cs ^= w[8*b +: 8];
                send_byte(w[8*b +: 8], 0, pre);
            end
            chk("full/wr_latency", 32'(imem_we), 32'd1);
        end
        send_byte(cs, 0, pre);
        chk("full/cpu_rst_before", 32'(pre), 32'd1);
        chk("full/cpu_rst", 32'(cpu_rst), 32'd0);
        chk("full/done", 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        chk("full/writes", 32'(n_writes), 32'd16);
        chk("full/error", 32'(error), 32'd0);
        chk("full/sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
